bullet_pool: RTL

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pkg.sv | 21 ++
 rtl/bullet_pool_box_painter.sv | 83 ++++++++
 rtl/bullet_pool.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_pkg.sv
// Shared constants and FSM state type for the bullet pool.
// CLEAR_TGT exists only when BULLET_TARGET_HIT_EN is defined.
package bullet_pkg;
    localparam logic [2:0] RED         = 3'b100;
    localparam logic [2:0] WHITE       = 3'b111;
    localparam int         SCREEN_W    = 160;
    localparam int         SCREEN_H    = 120;
    localparam int         TARGET_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        SCAN,
        ERASE,
        DRAW,
        DONE
`ifdef BULLET_TARGET_HIT_EN
        , CLEAR_TGT
`endif
    } state_t;
endpackage

// File: rtl/bullet_pool_box_painter.sv
// Walks a width x height box in raster order (x fastest), one pixel per cycle.
// Coordinates hold their last value while idle; a start on the done cycle chains boxes gaplessly.
module box_painter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_x,
    input  logic [6:0] start_y,
    input  logic [4:0] width,
    input  logic [4:0] height,
    input  logic [2:0] start_colour,
    output logic       plot,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic [2:0] colour,
    output logic       done
);
    logic       run_q, run_d;
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;
    logic [4:0] w_q, w_d, h_q, h_d, cx_q, cx_d, cy_q, cy_d;
    logic [2:0] col_q, col_d;
    logic       last;

    assign last   = run_q && (cx_q == w_q - 5'd1) && (cy_q == h_q - 5'd1);
    assign done   = last;
    assign plot   = run_q;
    assign px     = ox_q + {3'b000, cx_q};
    assign py     = oy_q + {2'b00, cy_q};
    assign colour = col_q;

    always_comb begin
        run_d = run_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        w_d   = w_q;
        h_d   = h_q;
        cx_d  = cx_q;
        cy_d  = cy_q;
        col_d = col_q;
        if (run_q && !last) begin
            if (cx_q == w_q - 5'd1) begin
                cx_d = 5'd0;
                cy_d = cy_q + 5'd1;
            end else begin
                cx_d = cx_q + 5'd1;
            end
        end
        if (last) run_d = 1'b0;
        if (start) begin
            run_d = 1'b1;
            ox_d  = start_x;
            oy_d  = start_y;
            w_d   = width;
            h_d   = height;
            col_d = start_colour;
            cx_d  = 5'd0;
            cy_d  = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            ox_q  <= '0;
            oy_q  <= '0;
            w_q   <= '0;
            h_q   <= '0;
            cx_q  <= '0;
            cy_q  <= '0;
            col_q <= '0;
        end else begin
            run_q <= run_d;
            ox_q  <= ox_d;
            oy_q  <= oy_d;
            w_q   <= w_d;
            h_q   <= h_d;
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: spawns, advances and retires bullet boxes, painting them through box_painter.
// Define BULLET_TARGET_HIT_EN to clear the target box and pulse hit on a row-matched retire.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int BULLET_SIZE = 4,
    parameter int X_LIMIT     = 144,
    parameter int STEP        = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fire,
    input  logic [7:0]             fire_x,
    input  logic [6:0]             fire_y,
    input  logic                   tick,
    input  logic [6:0]             target_y,
    output logic                   plot,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             colour,
    output logic                   busy,
    output logic                   fire_drop,
    output logic                   hit,
    output logic [NUM_BULLETS-1:0] active
);
    state_t                 state_q, state_d;
    logic                   fire_pend_q, fire_pend_d, tick_pend_q, tick_pend_d;
    logic                   sweep_q, sweep_d;
    logic [7:0]             fx_q, fx_d;
    logic [6:0]             fy_q, fy_d;
    logic [3:0]             idx_q, idx_d;
    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic [7:0]             slot_x_q [NUM_BULLETS];
    logic [7:0]             slot_x_d [NUM_BULLETS];
    logic [6:0]             slot_y_q [NUM_BULLETS];
    logic [6:0]             slot_y_d [NUM_BULLETS];

    logic       p_start, p_done;
    logic [7:0] p_x;
    logic [6:0] p_y;
    logic [4:0] p_w, p_h;
    logic [2:0] p_col;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic       free_found, cur_active, x_bad, y_bad, fits;
    logic [3:0] free_idx;
    logic [7:0] cur_x;
    logic [6:0] cur_y;
    logic [8:0] nx;

`ifdef BULLET_TARGET_HIT_EN
    logic hit_q, hit_d;
    assign hit = hit_q;
`else
    logic unused_target;
    assign unused_target = ^target_y;
    assign hit           = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign active    = active_q;
    assign fire_drop = (state_q == SPAWN) && (!free_found || x_bad || y_bad);
    assign x_bad     = ({1'b0, fx_q} + 9'(BULLET_SIZE)) > 9'(X_LIMIT);
    assign y_bad     = fy_q > 7'(SCREEN_H - BULLET_SIZE);
    // nx is 9 bits so a step past column 255 still counts as off the limit.
    assign nx        = {1'b0, cur_x} + 9'(STEP);
    assign fits      = (nx + 9'(BULLET_SIZE)) <= 9'(X_LIMIT);

    always_comb begin
        cur_active = 1'b0;
        cur_x      = '0;
        cur_y      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_active = active_q[i];
                cur_x      = slot_x_q[i];
                cur_y      = slot_y_q[i];
            end
        end
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fire_pend_d = fire_pend_q | fire;
        tick_pend_d = tick_pend_q | tick;
        sweep_d     = sweep_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        idx_d       = idx_q;
        active_d    = active_q;
        p_start     = 1'b0;
        p_x         = cur_x;
        p_y         = cur_y;
        p_w         = 5'(BULLET_SIZE);
        p_h         = 5'(BULLET_SIZE);
        p_col       = WHITE;
        wr_en       = 1'b0;
        wr_idx      = idx_q;
        wr_x        = cur_x;
        wr_y        = cur_y;
`ifdef BULLET_TARGET_HIT_EN
        hit_d       = 1'b0;
`endif
        if (fire && (!fire_pend_q || state_q == SPAWN)) begin
            fx_d = fire_x;
            fy_d = fire_y;
        end
        case (state_q)
            IDLE: begin
                if (fire_pend_q) begin
                    state_d = SPAWN;
                end else if (tick_pend_q) begin
                    state_d     = SCAN;
                    tick_pend_d = tick;
                    sweep_d     = 1'b1;
                    idx_d       = '0;
                end
            end
            SPAWN: begin
                fire_pend_d = fire;
                if (fire_drop) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAW;
                    sweep_d = 1'b0;
                    wr_en   = 1'b1;
                    wr_idx  = free_idx;
                    wr_x    = fx_q;
                    wr_y    = fy_q;
                    for (int i = 0; i < NUM_BULLETS; i++)
                        if (free_idx == 4'(i)) active_d[i] = 1'b1;
                    p_start = 1'b1;
                    p_x     = fx_q;
                    p_y     = fy_q;
                    p_col   = RED;
                end
            end
            SCAN: begin
                if (idx_q == 4'(NUM_BULLETS)) begin
                    state_d = DONE;
                end else if (cur_active) begin
                    state_d = ERASE;
                    p_start = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ERASE: begin
                if (p_done) begin
                    if (fits) begin
                        state_d = DRAW;
                        wr_en   = 1'b1;
                        wr_x    = nx[7:0];
                        p_start = 1'b1;
                        p_x     = nx[7:0];
                        p_col   = RED;
                    end else begin
                        for (int i = 0; i < NUM_BULLETS; i++)
                            if (idx_q == 4'(i)) active_d[i] = 1'b0;
                        state_d = SCAN;
                        idx_d   = idx_q + 4'd1;
`ifdef BULLET_TARGET_HIT_EN
                        if (cur_y == target_y) begin
                            state_d = CLEAR_TGT;
                            idx_d   = idx_q;
                            p_start = 1'b1;
                            p_x     = 8'(X_LIMIT);
                            p_w     = 5'(TARGET_SIZE);
                            p_h     = 5'(TARGET_SIZE);
                        end
`endif
                    end
                end
            end
            DRAW: begin
                if (p_done) begin
                    if (sweep_q) begin
                        state_d = SCAN;
                        idx_d   = idx_q + 4'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
`ifdef BULLET_TARGET_HIT_EN
            CLEAR_TGT: begin
                if (p_done) begin
                    hit_d   = 1'b1;
                    state_d = SCAN;
                    idx_d   = idx_q + 4'd1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_x_d = slot_x_q;
        slot_y_d = slot_y_q;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (wr_en && wr_idx == 4'(i)) begin
                slot_x_d[i] = wr_x;
                slot_y_d[i] = wr_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fire_pend_q <= 1'b0;
            tick_pend_q <= 1'b0;
            sweep_q     <= 1'b0;
            fx_q        <= '0;
            fy_q        <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                slot_x_q[i] <= '0;
                slot_y_q[i] <= '0;
            end
`ifdef BULLET_TARGET_HIT_EN
            hit_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fire_pend_q <= fire_pend_d;
            tick_pend_q <= tick_pend_d;
            sweep_q     <= sweep_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            slot_x_q    <= slot_x_d;
            slot_y_q    <= slot_y_d;
`ifdef BULLET_TARGET_HIT_EN
            hit_q       <= hit_d;
`endif
        end
    end

    box_painter u_painter (
        .clk          (clk),
        .reset        (reset),
        .start        (p_start),
        .start_x      (p_x),
        .start_y      (p_y),
        .width        (p_w),
        .height       (p_h),
        .start_colour (p_col),
        .plot         (plot),
        .px           (vga_x),
        .py           (vga_y),
        .colour       (colour),
        .done         (p_done)
    );
endmodule
